// File: rtl/sysarr_pkg.sv
// Shared widths for the systolic array: PE operand width and accumulator width.
package sysarr_pkg;
  localparam int ACC_WIDTH  = 16;
  localparam int DATA_WIDTH = 8;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count.
// A push into a full FIFO is accepted only if a pop happens on the same edge.
module sync_fifo #(
  parameter int width = 32,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [width-1:0]           push_data,
  input  logic                       pop_ready,
  output logic                       valid,
  output logic [width-1:0]           rd_data,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       dropped
);
  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = !empty && pop_ready;
  assign wr_en   = push && (!full || pop);
  assign dropped = push && full && !pop;
  assign valid   = !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers alone define what is visible.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/sys_arr_out_deskew.sv
// Collects the last PE row's skewed results, realigns the columns into one word
// and queues it for a valid/ready consumer, flagging drops and misalignment.
module sys_arr_out_deskew
  import sysarr_pkg::*;
#(
  parameter int row_width  = 2,
  parameter int fifo_depth = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [row_width-1:0]              activein,
  input  logic [ACC_WIDTH*row_width-1:0]    maccin,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [ACC_WIDTH*row_width-1:0]    out_data,
  output logic [$clog2(fifo_depth+1)-1:0]   count,
  output logic                              overflow,
  output logic                              skew_err
);
  logic [row_width-1:0]           dly_valid;
  logic [ACC_WIDTH*row_width-1:0] dly_data;
  logic                           all_valid;
  logic                           mixed;
  logic                           dropped;

  // Earlier columns wait longer so every column lines up with the last one.
  for (genvar i = 0; i < row_width; i++) begin : g_col
    localparam int D = row_width - 1 - i;
    if (D == 0) begin : g_direct
      assign dly_valid[i]                     = activein[i];
      assign dly_data[i*ACC_WIDTH +: ACC_WIDTH] = maccin[i*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_delay
      logic [D-1:0]         v_q;
      logic [ACC_WIDTH-1:0] d_q [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= '0;
          for (int k = 0; k < D; k++) d_q[k] <= '0;
        end else begin
          v_q[0] <= activein[i];
          d_q[0] <= activein[i] ? maccin[i*ACC_WIDTH +: ACC_WIDTH] : '0;
          for (int k = 1; k < D; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end
      assign dly_valid[i]                       = v_q[D-1];
      assign dly_data[i*ACC_WIDTH +: ACC_WIDTH] = d_q[D-1];
    end
  end

  assign all_valid = &dly_valid;
  assign mixed     = (|dly_valid) && !all_valid;

  sync_fifo #(
    .width (ACC_WIDTH*row_width),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (all_valid),
    .push_data (dly_data),
    .pop_ready (out_ready),
    .valid     (out_valid),
    .rd_data   (out_data),
    .count     (count),
    .dropped   (dropped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (dropped) overflow <= 1'b1;
      if (mixed)   skew_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sys_arr_out_deskew.sv
// Scoreboard bench for sys_arr_out_deskew at row_width=2, fifo_depth=4.
// Stimulus queues expected words; a negedge monitor checks each accepted word.
module tb_sys_arr_out_deskew;
  logic        clk;
  logic        rst;
  logic [1:0]  activein;
  logic [31:0] maccin;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  count;
  logic        overflow;
  logic        skew_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] sbq [$];

  sys_arr_out_deskew #(
    .row_width  (2),
    .fifo_depth (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .activein  (activein),
    .maccin    (maccin),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .skew_err  (skew_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Any accepted word must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total_cnt++;
      if (sbq.size() == 0) begin
        $display("[TB] FAIL monitor_unexpected: got word %h, required no word", out_data);
      end else begin
        logic [31:0] exp_w;
        exp_w = sbq.pop_front();
        if (out_data === exp_w) pass_cnt++;
        else $display("[TB] FAIL monitor_data: got %h, required %h", out_data, exp_w);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] act, input logic [31:0] data, input logic rdy);
    activein  = act;
    maccin    = data;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 32'h0, rdy);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle(2, 1'b0);
    rst = 1'b0;
  endtask

  // Non-overlapped word: column 0 then column 1 on the following cycle.
  task automatic sendWord(input logic [15:0] c0, input logic [15:0] c1, input logic rdy2, input logic expect_push);
    if (expect_push) sbq.push_back({c1, c0});
    applyStimulus(2'b01, {16'h0, c0}, 1'b0);
    applyStimulus(2'b10, {c1, 16'h0}, rdy2);
  endtask

  initial begin
    rst = 1'b1; activein = '0; maccin = '0; out_ready = 1'b0;
    doReset();
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_data",  out_data, 32'd0);
    checkOutput("reset_count",     {29'b0, count}, 32'd0);
    checkOutput("reset_overflow",  {31'b0, overflow}, 32'd0);
    checkOutput("reset_skew_err",  {31'b0, skew_err}, 32'd0);

    // Single word
    sendWord(16'h0011, 16'h0022, 1'b0, 1'b1);
    checkOutput("single_out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("single_out_data",  out_data, 32'h0022_0011);
    checkOutput("single_count",     {29'b0, count}, 32'd1);
    idle(2, 1'b1);
    idle(1, 1'b0);
    checkOutput("single_drained", {29'b0, count}, 32'd0);

    // Fill and overflow
    for (int k = 1; k <= 5; k++)
      sendWord(16'(k), 16'(k + 16'h100), 1'b0, k <= 4);
    idle(1, 1'b0);
    checkOutput("fill_count",    {29'b0, count}, 32'd4);
    checkOutput("fill_overflow", {31'b0, overflow}, 32'd1);
    checkOutput("fill_head",     out_data, 32'h0101_0001);
    idle(6, 1'b1);
    checkOutput("fill_out_valid_after", {31'b0, out_valid}, 32'd0);
    checkOutput("fill_count_after",     {29'b0, count}, 32'd0);

    // Full with simultaneous pop
    doReset();
    for (int k = 1; k <= 4; k++)
      sendWord(16'(16'h10 + k), 16'(16'h20 + k), 1'b0, 1'b1);
    sendWord(16'h0015, 16'h0025, 1'b1, 1'b1);
    out_ready = 1'b0;
    checkOutput("fullpop_count",    {29'b0, count}, 32'd4);
    checkOutput("fullpop_overflow", {31'b0, overflow}, 32'd0);
    checkOutput("fullpop_head",     out_data, 32'h0022_0012);
    idle(6, 1'b1);
    checkOutput("fullpop_drained", {29'b0, count}, 32'd0);

    // Skew error
    doReset();
    applyStimulus(2'b01, 32'h0000_0033, 1'b0);
    applyStimulus(2'b00, 32'h0, 1'b0);
    checkOutput("skew_flag",      {31'b0, skew_err}, 32'd1);
    checkOutput("skew_count",     {29'b0, count}, 32'd0);
    checkOutput("skew_out_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure stability
    doReset();
    sendWord(16'h00A1, 16'h00B1, 1'b0, 1'b1);
    sendWord(16'h00A2, 16'h00B2, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("hold_out_data",  out_data, 32'h00B1_00A1);
      idle(1, 1'b0);
    end
    idle(3, 1'b1);
    checkOutput("hold_drained", {29'b0, count}, 32'd0);

    // Overlapped stream at full rate
    doReset();
    sbq.push_back(32'h0C01_0B01);
    sbq.push_back(32'h0C02_0B02);
    sbq.push_back(32'h0C03_0B03);
    applyStimulus(2'b01, 32'h0000_0B01, 1'b1);
    applyStimulus(2'b11, 32'h0C01_0B02, 1'b1);
    applyStimulus(2'b11, 32'h0C02_0B03, 1'b1);
    checkOutput("stream_count", {29'b0, count}, 32'd1);
    checkOutput("stream_head",  out_data, 32'h0C02_0B02);
    applyStimulus(2'b10, 32'h0C03_0000, 1'b1);
    idle(3, 1'b1);
    checkOutput("stream_drained", {29'b0, count}, 32'd0);

    // Reset mid-word
    doReset();
    applyStimulus(2'b01, 32'h0000_0055, 1'b0);
    rst = 1'b1;
    applyStimulus(2'b10, 32'h0066_0000, 1'b0);
    rst = 1'b0;
    checkOutput("rstmid_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstmid_out_data",  out_data, 32'd0);
    checkOutput("rstmid_count",     {29'b0, count}, 32'd0);
    checkOutput("rstmid_flags",     {30'b0, overflow, skew_err}, 32'd0);
    idle(5, 1'b1);
    checkOutput("rstmid_no_word", {31'b0, out_valid}, 32'd0);

    checkOutput("scoreboard_empty", sbq.size(), 32'd0);
    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
